// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM_comb initiator: FSM state encoding and setup counter width.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      RESP   = 3'd3,
      VERIFY = 3'd4
   } state_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake bus between the datapath (master) and sram_ctrl (slave).
interface sram_ctrl_if #(
   parameter int W = 4,
   parameter int A = 2
);
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [A-1:0] req_addr;
   logic [W-1:0] req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_rdata;
   logic         rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/sram_ctrl_setup_cnt.sv
// Loadable down-counter timing the address/data setup interval; done while the count is zero.
module sram_ctrl_setup_cnt
   import sram_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Initiator-side controller for SRAM_comb: setup interval, one-cycle access, registered response.
// Define SRAM_CTRL_RDBACK_EN to add a write read-back VERIFY cycle that flags mismatches on rsp_err.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int N         = 4,
   parameter int W         = 4,
   parameter int A         = $clog2(N),
   parameter int SETUP_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   sram_ctrl_if.slave   bus,
   output logic         sram_cs,
   output logic         sram_wr_en,
   output logic [A-1:0] sram_addr,
   output logic [W-1:0] sram_wr_data,
   input  logic [W-1:0] sram_rd_data
);

   state_t       state;
   logic         we_q;
   logic         rsp_valid_q;
   logic [W-1:0] rsp_rdata_q;
   logic         rsp_err_q;
   logic         accept;
   logic         in_range;
   logic         cnt_done;

   assign bus.req_ready = (state == IDLE) && !rst;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign accept   = bus.req_valid && bus.req_ready;
   assign in_range = int'(bus.req_addr) < N;

   sram_ctrl_setup_cnt u_setup_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && in_range),
      .load_val (CNT_W'(SETUP_CYC - 1)),
      .dec      (state == SETUP),
      .done     (cnt_done)
   );

   // sram_addr/sram_wr_data double as the latched request; they are only loaded for in-range requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         sram_cs      <= 1'b0;
         sram_wr_en   <= 1'b0;
         sram_addr    <= '0;
         sram_wr_data <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q <= bus.req_we;
                  if (in_range) begin
                     sram_cs      <= 1'b1;
                     sram_addr    <= bus.req_addr;
                     sram_wr_data <= bus.req_wdata;
                     rsp_err_q    <= 1'b0;
                     state        <= SETUP;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     state       <= RESP;
                  end
               end
            end
            SETUP: begin
               if (cnt_done) begin
                  sram_wr_en <= we_q;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               sram_wr_en  <= 1'b0;
               rsp_rdata_q <= we_q ? '0 : sram_rd_data;
`ifdef SRAM_CTRL_RDBACK_EN
               if (we_q) begin
                  state <= VERIFY;
               end else begin
                  sram_cs     <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end
`else
               sram_cs     <= 1'b0;
               rsp_valid_q <= 1'b1;
               state       <= RESP;
`endif
            end
`ifdef SRAM_CTRL_RDBACK_EN
            // The write landed at the end of ACCESS, so the array now shows the stored word.
            VERIFY: begin
               sram_cs     <= 1'b0;
               rsp_err_q   <= (sram_rd_data != sram_wr_data);
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
`endif
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl (N=3, W=4, SETUP_CYC=2) with a combinational SRAM model.
module tb_sram_ctrl;

   localparam int N  = 3;
   localparam int W  = 4;
   localparam int A  = 2;
   localparam int SC = 2;

   logic         clk;
   logic         rst;
   logic         sram_cs;
   logic         sram_wr_en;
   logic [A-1:0] sram_addr;
   logic [W-1:0] sram_wr_data;
   logic [W-1:0] sram_rd_data;

   sram_ctrl_if #(.W(W), .A(A)) bus ();

   sram_ctrl #(.N(N), .W(W), .A(A), .SETUP_CYC(SC)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .sram_cs      (sram_cs),
      .sram_wr_en   (sram_wr_en),
      .sram_addr    (sram_addr),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data)
   );

   typedef struct {
      logic [W-1:0] rdata;
      logic         err;
      int           exp_edge;
      logic [A-1:0] addr;
      logic [W-1:0] wdata;
      int           cs_cyc;
      int           we_cyc;
   } exp_t;

   exp_t     exp_q[$];
   exp_t     cur;
   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   int       cs_cnt = 0;
   int       we_cnt = 0;
   bit       was_valid = 0;
   bit       corrupt = 0;
   bit       mem_clr = 1;
   logic [W-1:0] mem [0:N-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM_comb model: combinational read, write on the clock edge while cs and wr_en are high.
   always_comb begin
      sram_rd_data = '0;
      if (!corrupt && (int'(sram_addr) < N)) sram_rd_data = mem[sram_addr];
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (sram_cs && sram_wr_en && (int'(sram_addr) < N)) begin
         mem[sram_addr] <= sram_wr_data;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int wrLat();
`ifdef SRAM_CTRL_RDBACK_EN
      return SC + 3;
`else
      return SC + 2;
`endif
   endfunction

   function automatic int wrCs();
`ifdef SRAM_CTRL_RDBACK_EN
      return SC + 2;
`else
      return SC + 1;
`endif
   endfunction

   // Issues one request, pushes its expected response at the accept edge, then churns req_* inputs.
   task automatic applyStimulus(input logic we, input logic [A-1:0] addr, input logic [W-1:0] wdata,
                                input logic [W-1:0] exp_rdata, input logic exp_err);
      int   guard = 0;
      int   lat;
      int   csc;
      int   wec;
      exp_t item;
      if (int'(addr) >= N) begin
         lat = 1; csc = 0; wec = 0;
      end else begin
         lat = we ? wrLat() : SC + 2;
         csc = we ? wrCs() : SC + 1;
         wec = we ? 1 : 0;
      end
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (!bus.req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=0 required=1");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      item.rdata    = exp_rdata;
      item.err      = exp_err;
      item.exp_edge = cyc + lat - 1;
      item.addr     = addr;
      item.wdata    = wdata;
      item.cs_cyc   = csc;
      item.we_cyc   = wec;
      exp_q.push_back(item);
      bus.req_valid = 1'b0;
      for (int i = 0; i < SC + 2; i++) begin
         @(negedge clk);
         bus.req_addr  = A'($urandom);
         bus.req_wdata = W'($urandom);
      end
   endtask

   task automatic waitIdle();
      int g = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0 || bus.rsp_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout actual=%0d required=0", exp_q.size());
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_cs", sram_cs, 0);
      checkOutput("rst_wr_en", sram_wr_en, 0);
      checkOutput("rst_addr", sram_addr, 0);
      checkOutput("rst_wr_data", sram_wr_data, 0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
      checkOutput("rst_rsp_err", bus.rsp_err, 0);
      checkOutput("rst_req_ready", bus.req_ready, 0);
   endtask

   // Monitor: pops the scoreboard on each new response and checks holds while the response waits.
   always @(negedge clk) begin
      if (rst) begin
         was_valid = 1'b0;
         cs_cnt    = 0;
         we_cnt    = 0;
      end else begin
         if (sram_cs) begin
            cs_cnt++;
            if (exp_q.size() > 0) begin
               checkOutput("sram_addr_hold", sram_addr, exp_q[0].addr);
               checkOutput("sram_wr_data_hold", sram_wr_data, exp_q[0].wdata);
            end
         end
         if (sram_wr_en) we_cnt++;
         if (bus.rsp_valid) begin
            checkOutput("req_ready_low_in_rsp", bus.req_ready, 0);
            if (!was_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_rsp actual=1 required=0");
               end else begin
                  cur = exp_q.pop_front();
                  checkOutput("rsp_rdata", bus.rsp_rdata, cur.rdata);
                  checkOutput("rsp_err", bus.rsp_err, cur.err);
                  checkOutput("rsp_latency_edge", cyc, cur.exp_edge);
                  checkOutput("sram_cs_cycles", cs_cnt, cur.cs_cyc);
                  checkOutput("sram_wr_en_cycles", we_cnt, cur.we_cyc);
               end
               cs_cnt = 0;
               we_cnt = 0;
            end else begin
               checkOutput("rsp_rdata_stable", bus.rsp_rdata, cur.rdata);
               checkOutput("rsp_err_stable", bus.rsp_err, cur.err);
            end
         end
         was_valid = bus.rsp_valid;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState();
      mem_clr = 1'b0;
      rst     = 1'b0;
      #1;
      checkOutput("req_ready_after_rst", bus.req_ready, 1);

      // Directed vectors: write/read-back, out-of-range read and write.
      applyStimulus(1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
      applyStimulus(1'b0, 2'd2, 4'h0, 4'hA, 1'b0);
      applyStimulus(1'b0, 2'd3, 4'h0, 4'h0, 1'b1);
      applyStimulus(1'b1, 2'd0, 4'h5, 4'h0, 1'b0);
      applyStimulus(1'b1, 2'd1, 4'hC, 4'h0, 1'b0);
      applyStimulus(1'b0, 2'd0, 4'h0, 4'h5, 1'b0);
      applyStimulus(1'b0, 2'd1, 4'h0, 4'hC, 1'b0);
      applyStimulus(1'b1, 2'd3, 4'hF, 4'h0, 1'b1);
      applyStimulus(1'b0, 2'd2, 4'h0, 4'hA, 1'b0);
      waitIdle();

      // Reset in the middle of SETUP: the aborted write must neither respond nor reach the array.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 2'd1;
      bus.req_wdata = 4'h3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("mid_setup_cs", sram_cs, 1);
      rst = 1'b1;
      #1;
      checkOutput("req_ready_in_rst", bus.req_ready, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState();
      rst = 1'b0;
      #1;
      checkOutput("req_ready_release", bus.req_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("no_stray_rsp_valid", bus.rsp_valid, 0);
         checkOutput("no_stray_cs", sram_cs, 0);
      end
      applyStimulus(1'b0, 2'd1, 4'h0, 4'hC, 1'b0);
      waitIdle();

      // Backpressure: response held for several cycles, then accept resumes right after the handshake.
      bus.rsp_ready = 1'b0;
      applyStimulus(1'b0, 2'd0, 4'h0, 4'h5, 1'b0);
      for (int g = 0; g < 20 && !bus.rsp_valid; g++) @(negedge clk);
      checkOutput("bp_rsp_seen", bus.rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_valid_held", bus.rsp_valid, 1);
         checkOutput("bp_req_ready_low", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_valid_drop", bus.rsp_valid, 0);
      checkOutput("bp_accept_resumes", bus.req_ready, 1);
      applyStimulus(1'b0, 2'd2, 4'h0, 4'hA, 1'b0);
      waitIdle();

`ifdef SRAM_CTRL_RDBACK_EN
      // Read-back: a faulty array returning zero makes the write of 4'h5 report an error.
      corrupt = 1'b1;
      applyStimulus(1'b1, 2'd1, 4'h5, 4'h0, 1'b1);
      waitIdle();
      corrupt = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator-side controller for the SRAM_comb memory. It accepts single read/write requests from the processor datapath over a valid/ready handshake.
- It drives SRAM_comb's cs, wr_en, addr and wr_data pins with a programmable address/data setup interval, then performs a one-cycle access.
- It captures rd_data on reads and returns a registered response with its own valid/ready handshake.

Parameters:
- N, 4, number of SRAM words; must match the attached SRAM_comb instance.
- W, 4, data word width in bits.
- A, $clog2(N), address width in bits.
- SETUP_CYC, 1, cycles addr/wr_data are held with cs=1, wr_en=0 before the access cycle; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  A  word address.
- req_wdata  in  W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  W  read data; 0 for writes.
- rsp_err  out  1  address out of range (plus readback mismatch when the optional feature is enabled).
- sram_cs  out  1  drives SRAM_comb cs.
- sram_wr_en  out  1  drives SRAM_comb wr_en.
- sram_addr  out  A  drives SRAM_comb addr.
- sram_wr_data  out  W  drives SRAM_comb wr_data.
- sram_rd_data  in  W  from SRAM_comb rd_data (combinational on the SRAM side).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- While rst=1 at a posedge:
  - state goes to IDLE.
  - sram_cs, sram_wr_en, sram_addr, sram_wr_data, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - req_ready=0 while rst is high.
  - Reset mid-transaction aborts the transaction with no response.
- States: IDLE, SETUP, ACCESS, RESP (plus VERIFY when the optional feature is built in). All outputs are registered except req_ready = (state==IDLE) && !rst.
- IDLE:
  - sram_cs=0, sram_wr_en=0.
  - On req_valid && req_ready, latch we/addr/wdata.
  - If addr >= N: go to RESP with rsp_err=1 and rsp_rdata=0; no SRAM cycle is issued.
  - Otherwise: go to SETUP with setup counter = SETUP_CYC-1.
- SETUP:
  - sram_cs=1, sram_wr_en=0; sram_addr and sram_wr_data hold the latched values, stable for the whole state.
  - The counter decrements each cycle; at 0, go to ACCESS.
  - Lasts exactly SETUP_CYC cycles.
- ACCESS (exactly 1 cycle):
  - sram_cs=1.
  - sram_wr_en = latched we.
  - Read: rsp_rdata <= sram_rd_data at the end of the cycle.
  - Write: rsp_rdata <= 0.
  - Next state: RESP.
- RESP:
  - sram_cs=0, sram_wr_en=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held until rsp_valid && rsp_ready, then go to IDLE.
  - rsp_valid drops on the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: request accepted at edge k → rsp_valid=1 from cycle k+SETUP_CYC+2. Out-of-range requests → rsp_valid=1 from k+1.
- Throughput: one outstanding transaction; back-to-back requests are separated by at least one IDLE cycle.
- sram_addr and sram_wr_data retain their last values in IDLE and RESP; only cs gates the SRAM.
- Inputs changing on req_* after acceptance have no effect.

Optional Feature:
- Macro: SRAM_CTRL_RDBACK_EN.
- Defined:
  - Writes go ACCESS → VERIFY: 1 cycle with sram_cs=1, sram_wr_en=0, same address.
  - Compare sram_rd_data to the latched wdata; on mismatch rsp_err=1.
  - Then go to RESP. Write latency becomes SETUP_CYC+3.
- Undefined: VERIFY does not exist; rsp_err reflects only the range check.

Decomposition:
- Shared package/include sram_ctrl_defs:
  - state encodings: IDLE=0, SETUP=1, ACCESS=2, RESP=3, VERIFY=4; 3-bit state.
  - SETUP counter width: 4 bits.
- One natural sub-module: sram_ctrl_setup_cnt.
  - Loadable down-counter with load and done ports; W-independent.
- Everything else stays in sram_ctrl.

Test Plan:
1. Reset: hold rst for 3 cycles mid-SETUP → all outputs 0, req_ready=0; on release req_ready=1 and no stray rsp_valid.
2. Write then read with N=4, W=4, SETUP_CYC=2:
   - Write addr=2, data=4'hA, then read addr=2.
   - Expected: rsp_rdata=4'hA, rsp_err=0.
   - rsp_valid first seen 4 cycles after each accept.
   - sram_cs high for 3 cycles; sram_wr_en high for exactly 1 cycle during the write.
3. Out of range with N=3, A=2: read addr=3 → rsp_valid the next cycle, rsp_err=1, rsp_rdata=0, sram_cs never asserted.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_rdata stable, req_ready=0 throughout; accept resumes 1 cycle after the handshake.
5. Input churn: change req_addr/req_wdata every cycle after accept → sram_addr/sram_wr_data stay constant through SETUP and ACCESS.
6. SRAM_CTRL_RDBACK_EN defined, SRAM model forced to return 4'h0 on a write of 4'h5 → rsp_err=1, write latency SETUP_CYC+3.
